// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type, default timing constants and helpers for btn_repeat
package btn_pkg;
  typedef enum logic [2:0] {LOCK, IDLE, DELAY, REPEAT, HELD} btn_state_e;
  localparam int BTN_HOLD_MS_DEF = 500;
  localparam int BTN_REPEAT_MS_DEF = 100;
  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/btn_timer.sv
// btn_timer: up counter with synchronous clear and terminal-count compare
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear to 0 (wins over en_i)
//   en_i         : count up by one
//   term_i       : terminal value to compare against
//   tc_o         : high while the count equals term_i
module btn_timer #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc_o = (cnt_q == term_i);
endmodule

// File: rtl/btn_repeat.sv
// btn_repeat: debounced button level to one-cycle action pulses with hold-to-repeat
//   clk_1khz  : 1 kHz clock, rising edge
//   rst       : synchronous active-high reset
//   btn_in    : debounced button level, 1 = pressed
//   btn_pulse : registered one-cycle pulse on press and on each repeat
//   btn_long  : registered level, high while held >= HOLD_MS cycles
// Define BTN_REPEAT_EN for hold-to-repeat; without it a hold only raises btn_long.
module btn_repeat import btn_pkg::*; #(
  parameter int HOLD_MS   = BTN_HOLD_MS_DEF,
  parameter int REPEAT_MS = BTN_REPEAT_MS_DEF
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic btn_in,
  output logic btn_pulse,
  output logic btn_long
);
  localparam int CW = $clog2(btn_max(HOLD_MS, REPEAT_MS));
  btn_state_e state_q, state_d;
  logic pulse_q, pulse_d, long_q, long_d, clr, en, tc;
  logic [CW-1:0] term;
  assign term = (state_q == DELAY) ? CW'(HOLD_MS - 1) : CW'(REPEAT_MS - 1);
  btn_timer #(.W(CW)) u_timer (
    .clk_i (clk_1khz),
    .rst_i (rst),
    .clr_i (clr),
    .en_i  (en),
    .term_i(term),
    .tc_o  (tc)
  );
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q <= LOCK;
      pulse_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      long_q  <= long_d;
    end
  end
  // Release is tested before terminal count so a release on the terminal edge wins.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    long_d  = long_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      LOCK: begin
        clr = 1'b1;
        if (!btn_in) state_d = IDLE;
      end
      IDLE: begin
        clr = 1'b1;
        if (btn_in) begin
          pulse_d = 1'b1;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (!btn_in) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (tc) begin
          clr     = 1'b1;
          long_d  = 1'b1;
`ifdef BTN_REPEAT_EN
          pulse_d = 1'b1;
          state_d = REPEAT;
`else
          state_d = HELD;
`endif
        end else begin
          en = 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_in) begin
          clr     = 1'b1;
          long_d  = 1'b0;
          state_d = IDLE;
        end else if (tc) begin
          clr     = 1'b1;
          pulse_d = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      HELD: begin
        if (!btn_in) begin
          long_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = LOCK;
    endcase
  end
  assign btn_pulse = pulse_q;
  assign btn_long  = long_q;
endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: directed and randomized checks of btn_repeat against a hold-duration model
module tb_btn_repeat;
  localparam int H = 500;
  localparam int R = 100;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk_1khz = 1'b0;
  logic rst, btn_in, btn_pulse, btn_long;
  int n_assert = 0;
  int n_fail = 0;
  int h = 0;
  bit locked = 1'b1;
  int npulse = 0;
  bit saw_long = 1'b0;
  btn_repeat #(.HOLD_MS(H), .REPEAT_MS(R)) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_pulse(btn_pulse),
    .btn_long (btn_long)
  );
  always #5 clk_1khz = ~clk_1khz;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (h=%0d)", tag, obs, exp, h);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // h counts consecutive sampled-high edges of the current press (1 at E0).
  task automatic step(input logic r, input logic b);
    logic ep, el;
    rst = r;
    btn_in = b;
    @(posedge clk_1khz);
    #1;
    if (r) begin
      locked = 1'b1;
      h = 0;
    end else if (locked) begin
      if (!b) locked = 1'b0;
      h = 0;
    end else begin
      h = b ? h + 1 : 0;
    end
    el = (h - 1 >= H);
    ep = (h == 1) || (REP && el && ((h - 1 - H) % R == 0));
    chk("btn_pulse", btn_pulse, ep);
    chk("btn_long", btn_long, el);
    npulse += int'(btn_pulse);
    saw_long |= btn_long;
  endtask
  task automatic hold(input logic b, input int n);
    repeat (n) step(1'b0, b);
  endtask
  task automatic clr_stats();
    npulse = 0;
    saw_long = 1'b0;
  endtask
  initial begin
    repeat (3) step(1'b1, 1'b1);
    clr_stats();
    hold(1'b1, 50);
    chk_i("lock_hold_pulses", npulse, 0);
    hold(1'b0, 1);
    hold(1'b1, 1);
    chk_i("after_lock_press", npulse, 1);
    hold(1'b1, 5);
    hold(1'b0, 3);
    clr_stats();
    hold(1'b1, 20);
    hold(1'b0, 5);
    chk_i("short_pulses", npulse, 1);
    chk("short_long", saw_long, 1'b0);
    clr_stats();
    hold(1'b1, 800);
    chk_i("hold800_pulses", npulse, REP ? 4 : 1);
    chk("hold800_long", saw_long, 1'b1);
    hold(1'b0, 4);
    clr_stats();
    hold(1'b1, H);
    hold(1'b0, 1);
    chk_i("rel_at_term_pulses", npulse, 1);
    chk("rel_at_term_long", saw_long, 1'b0);
    hold(1'b1, 520);
    hold(1'b0, 1);
    clr_stats();
    hold(1'b1, H);
    hold(1'b0, 1);
    chk_i("repress_pulses", npulse, 1);
    chk("repress_long", saw_long, 1'b0);
    hold(1'b1, 650);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    clr_stats();
    hold(1'b1, 20);
    chk_i("reset_mid_pulses", npulse, 0);
    hold(1'b0, 2);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, 1'($urandom_range(0, 1)));
      hold(1'b1, $urandom_range(1, 750));
      hold(1'b0, $urandom_range(1, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
